output_drain_arbiter: RTL and testbench
=======================================

Name: output_drain_arbiter

Overview:
Shares one downstream quantize/activate unit among NUM_BUFFERS array output buffers. It drains one systolic tile. Every output it drains comes from a buffer's single read port, and it serves the buffers round-robin. It passes each output, with its row/col tag, through one registered stage into the quantizer. It raises done once exactly tile_count outputs have been delivered downstream.

Parameters:
NUM_BUFFERS, 4, number of output buffers served (>=2, power of two)
MAX_N, 512, maximum matrix dimension
N_BITS, $clog2(MAX_N), row/col tag width
CNT_BITS, 2*N_BITS+1, width of tile output counters (holds MAX_N*MAX_N)
GNT_BITS, $clog2(NUM_BUFFERS), grant index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  begin draining a tile; honoured only in IDLE
tile_count  in  CNT_BITS  number of outputs expected this tile; latched on accepted start
buf_valid  in  [NUM_BUFFERS] x 1  per-buffer output valid
buf_output  in  [NUM_BUFFERS] x int32_t  per-buffer unquantized value
buf_row  in  [NUM_BUFFERS] x N_BITS  per-buffer row tag
buf_col  in  [NUM_BUFFERS] x N_BITS  per-buffer col tag
buf_consume  out  [NUM_BUFFERS] x 1  per-buffer consume (read acknowledge)
q_valid  out  1  output to quantizer valid
q_output  out  int32_t  value to quantizer
q_row  out  N_BITS  row tag
q_col  out  N_BITS  col tag
q_ready  in  1  quantizer accepts this cycle
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse when tile complete

Behaviour:
- Reset: state=IDLE, grant_q=0, captured=0, delivered=0, expected=0, q_valid=0, q_output/q_row/q_col=0, buf_consume all 0, busy=0, done=0. A reset mid-tile abandons the tile. Data the buffers have already handed over is dropped without a done.
- States: IDLE, DRAIN, FLUSH, DONE (enum in package).
- IDLE, start=1: latch expected=tile_count, clear captured/delivered, go to DRAIN next cycle.
- DRAIN:
  - buf_consume[i] = (i==grant_q) && slot_free && (captured<expected), where slot_free = !q_valid || q_ready.
  - buf_consume must not depend combinationally on any buf_valid. A buffer's valid may depend on its own consume (bypass path), so this rule breaks that loop.
  - Capture occurs when buf_consume[grant_q] && buf_valid[grant_q]. The data is loaded into the q register, q_valid is set next cycle, and captured increments. Latency: buffer to q_valid is 1 cycle.
  - An asserted consume without valid is harmless and counts nothing.
- Grant update, each DRAIN cycle:
  - If capture occurred, or buf_valid[grant_q]=0: grant_q moves to the first i with buf_valid[i]=1, searching from grant_q+1 upward and wrapping modulo NUM_BUFFERS, excluding grant_q. If no such i exists, grant_q holds.
  - If buf_valid[grant_q]=1 but slot_free=0 (backpressure): grant_q holds.
- q register:
  - When q_valid=1 && q_ready=0, q_output/row/col stay stable.
  - A new capture may load in the same cycle that q_ready retires the old entry.
  - delivered increments on q_valid && q_ready.
- Transitions:
  - DRAIN goes to FLUSH when captured reaches expected; consumes then stop.
  - FLUSH goes to DONE when delivered reaches expected. This may happen on the same cycle as entry to FLUSH if already equal.
  - DONE asserts done=1 for exactly one cycle, then returns to IDLE.
  - tile_count=0: start, then DRAIN (captured==expected), then FLUSH, then DONE. done asserts 3 cycles after start; no consume is ever asserted.
- start outside IDLE is ignored. Counters are unsigned and saturate at expected; neither may exceed it.

Decomposition:
- Shared package: arbiter state enum, plus reuse of int32_t from sys_types.
- One sub-module: rr_priority_picker (inputs: request vector, current index; outputs: next index, found). It is purely combinational and reusable by other arbiters.

Test Plan:
1. Reset assertion while in DRAIN with q_valid=1: next cycle all outputs are 0, state is IDLE, and no done pulse occurs.
2. start with tile_count=4; buffers 0..3 each hold one entry (10,20,30,40; row=i, col=i); q_ready=1.
   - q sequence is 10,20,30,40 on consecutive cycles.
   - done pulses one cycle after the 40 handshake.
   - Each buf_consume is high exactly once with valid.
3. As scenario 2, but q_ready=0 for 3 cycles after the first q_valid:
   - q_output holds 10 for all 3 cycles.
   - buf_consume stays all 0.
   - Draining resumes with 20 the cycle q_ready returns.
4. tile_count=6; only buffers 0 and 2 are continuously valid, with values 100+k and 200+k.
   - Grant alternates, giving q order 100,200,101,201,102,202.
   - Buffers 1 and 3 never get consume while valid.
5. tile_count=0: done pulses 3 cycles after start; buf_consume never asserted; q_valid stays 0.
6. tile_count=2 while 5 entries are available: exactly 2 captures, then consumes stop. A start pulse during FLUSH is ignored, and busy stays high until done.

Source files
------------

// File: rtl/output_drain_arbiter_pkg.sv
// Types shared by the output drain arbiter and its picker.
// No timing behaviour; types only.
// No flow control; types only.
package output_drain_arbiter_pkg;
  import sys_types::*;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;
endpackage

// File: rtl/sys_types.sv
// Shared scalar types for the datapath.
// No timing behaviour; types only.
// No flow control; types only.
package sys_types;
  typedef logic signed [31:0] int32_t;
endpackage

// File: rtl/output_drain_arbiter_rr_priority_picker.sv
// Round-robin picker: first requester after cur, wrapping, excluding cur.
// Purely combinational, zero latency.
// No flow control; found=0 and nxt=cur when no other requester is active.
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt,
  output logic         found
);
  logic [W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int k = N - 1; k >= 1; k--) begin
      idx = cur + W'(k);
      if (req[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_drain_arbiter.sv
// Drains one tile from NUM_BUFFERS output buffers round-robin into one quantizer stage.
// Latency: buffer capture to q_valid is 1 cycle; done pulses 1 cycle after the last handshake.
// Backpressure: q_valid && !q_ready freezes the q register and withholds all consumes.
module output_drain_arbiter
  import sys_types::*;
  import output_drain_arbiter_pkg::*;
#(
  parameter int NUM_BUFFERS = 4,
  parameter int MAX_N       = 512,
  parameter int N_BITS      = $clog2(MAX_N),
  parameter int CNT_BITS    = 2 * N_BITS + 1,
  parameter int GNT_BITS    = $clog2(NUM_BUFFERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_BITS-1:0]    tile_count,
  input  logic [NUM_BUFFERS-1:0] buf_valid,
  input  int32_t                 buf_output [NUM_BUFFERS],
  input  logic [N_BITS-1:0]      buf_row    [NUM_BUFFERS],
  input  logic [N_BITS-1:0]      buf_col    [NUM_BUFFERS],
  output logic [NUM_BUFFERS-1:0] buf_consume,
  output logic                   q_valid,
  output int32_t                 q_output,
  output logic [N_BITS-1:0]      q_row,
  output logic [N_BITS-1:0]      q_col,
  input  logic                   q_ready,
  output logic                   busy,
  output logic                   done
);
  arb_state_e          state;
  logic [GNT_BITS-1:0] grant_q;
  logic [GNT_BITS-1:0] next_grant;
  logic                found;
  logic [CNT_BITS-1:0] captured;
  logic [CNT_BITS-1:0] delivered;
  logic [CNT_BITS-1:0] expected;
  logic [CNT_BITS-1:0] captured_nx;
  logic [CNT_BITS-1:0] delivered_nx;
  logic                slot_free;
  logic                can_take;
  logic                capture;
  logic                deliver;

  // Consume is built only from registered state and q_ready, never from buf_valid,
  // so a buffer may bypass its valid from its own consume without a loop.
  assign slot_free    = !q_valid || q_ready;
  assign can_take     = (state == ST_DRAIN) && slot_free && (captured < expected);
  assign capture      = can_take && buf_valid[grant_q];
  assign deliver      = q_valid && q_ready && (delivered < expected);
  assign captured_nx  = captured + {{(CNT_BITS-1){1'b0}}, capture};
  assign delivered_nx = delivered + {{(CNT_BITS-1){1'b0}}, deliver};
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  // One-hot consume toward the granted buffer.
  always_comb begin
    buf_consume          = '0;
    buf_consume[grant_q] = can_take;
  end

  rr_priority_picker #(
    .N (NUM_BUFFERS),
    .W (GNT_BITS)
  ) u_picker (
    .req   (buf_valid),
    .cur   (grant_q),
    .nxt   (next_grant),
    .found (found)
  );

  // Tile sequencing, counters and grant rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      captured  <= '0;
      delivered <= '0;
      expected  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            expected  <= tile_count;
            captured  <= '0;
            delivered <= '0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          captured  <= captured_nx;
          delivered <= delivered_nx;
          // Move on after a capture or off an idle buffer; hold under backpressure.
          if ((capture || !buf_valid[grant_q]) && found) begin
            grant_q <= next_grant;
          end
          if (captured_nx == expected) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          delivered <= delivered_nx;
          if (delivered_nx == expected) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Single output stage: load on capture, retire on q_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid  <= 1'b0;
      q_output <= '0;
      q_row    <= '0;
      q_col    <= '0;
    end else if (capture) begin
      q_valid  <= 1'b1;
      q_output <= buf_output[grant_q];
      q_row    <= buf_row[grant_q];
      q_col    <= buf_col[grant_q];
    end else if (q_ready) begin
      q_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_output_drain_arbiter.sv
// Self-checking bench for output_drain_arbiter with a queue-based buffer model.
// Checks cycle timing of directed scenarios and order against a round-robin model.
// q_ready is driven directly, both scripted and randomized.
module tb_output_drain_arbiter;
  import sys_types::*;

  localparam int NB = 4;
  localparam int NBITS = 9;
  localparam int CB = 19;

  typedef struct packed {
    logic [31:0]      val;
    logic [NBITS-1:0] row;
    logic [NBITS-1:0] col;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CB-1:0]     tile_count = '0;
  logic [NB-1:0]     buf_valid = '0;
  int32_t            buf_output [NB];
  logic [NBITS-1:0]  buf_row [NB];
  logic [NBITS-1:0]  buf_col [NB];
  logic [NB-1:0]     buf_consume;
  logic              q_valid;
  int32_t            q_output;
  logic [NBITS-1:0]  q_row;
  logic [NBITS-1:0]  q_col;
  logic              q_ready = 1'b1;
  logic              busy;
  logic              done;

  ent_t bq [NB][$];
  ent_t mq [NB][$];
  ent_t obs[$];
  ent_t expq[$];
  int   obs_cyc[$];
  int   cons_cnt [NB];
  int   cons_cyc [NB];
  int   cons_any, done_cnt, done_cyc, qv_cnt, cyc;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  output_drain_arbiter dut (
    .clk(clk), .reset(reset), .start(start), .tile_count(tile_count),
    .buf_valid(buf_valid), .buf_output(buf_output), .buf_row(buf_row), .buf_col(buf_col),
    .buf_consume(buf_consume), .q_valid(q_valid), .q_output(q_output), .q_row(q_row),
    .q_col(q_col), .q_ready(q_ready), .busy(busy), .done(done)
  );

  task automatic drive_bufs();
    for (int i = 0; i < NB; i++) begin
      if (bq[i].size() > 0) begin
        buf_valid[i]  = 1'b1;
        buf_output[i] = bq[i][0].val;
        buf_row[i]    = bq[i][0].row;
        buf_col[i]    = bq[i][0].col;
      end else begin
        buf_valid[i]  = 1'b0;
        buf_output[i] = 0;
        buf_row[i]    = '0;
        buf_col[i]    = '0;
      end
    end
  endtask

  task automatic push_ent(input int b, input logic [31:0] v, input logic [NBITS-1:0] r, input logic [NBITS-1:0] c);
    ent_t e;
    e.val = v; e.row = r; e.col = c;
    bq[b].push_back(e);
  endtask

  // One clock: sample at negedge, pop consumed entries just after posedge.
  task automatic cycle();
    logic [NB-1:0] pop;
    ent_t e;
    @(negedge clk);
    pop = '0;
    for (int i = 0; i < NB; i++) begin
      if (buf_consume[i]) begin
        cons_any++;
        if (buf_valid[i]) begin
          pop[i] = 1'b1;
          cons_cnt[i]++;
          cons_cyc[i] = cyc;
        end
      end
    end
    if (q_valid) qv_cnt++;
    if (q_valid && q_ready) begin
      e.val = q_output; e.row = q_row; e.col = q_col;
      obs.push_back(e);
      obs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) if (pop[i]) void'(bq[i].pop_front());
    drive_bufs();
    cyc++;
  endtask

  task automatic clear_log();
    obs.delete(); obs_cyc.delete();
    for (int i = 0; i < NB; i++) begin cons_cnt[i] = 0; cons_cyc[i] = -1; end
    cons_any = 0; done_cnt = 0; done_cyc = -1; qv_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; q_ready = 1'b1; tile_count = '0;
    for (int i = 0; i < NB; i++) bq[i].delete();
    drive_bufs();
    cycle(); cycle();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic pulse_start(input int tc);
    tile_count = CB'(tc);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit, input string name);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin cycle(); n++; end
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, limit);
    end
  endtask

  function automatic int next_ne(input int p);
    for (int k = 1; k < NB; k++) if (mq[(p + k) % NB].size() > 0) return (p + k) % NB;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; q_ready = 1'b1;
    for (int i = 0; i < NB; i++) bq[i].delete();
    drive_bufs();
    cycle(); cycle();
    n_checks++;
    if (q_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || buf_consume !== '0 || q_output !== 0) begin
      n_fail++;
      $display("FAIL reset_state: q_valid=%b busy=%b done=%b consume=%b q_output=%0d, want all 0", q_valid, busy, done, buf_consume, q_output);
    end
    reset = 1'b0;
    clear_log();
    for (int i = 0; i < NB; i++) push_ent(i, 32'(10 * (i + 1)), NBITS'(i), NBITS'(i));
    drive_bufs();
    q_ready = 1'b0;
    pulse_start(4);
    cycle();
    n_checks++;
    if (q_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midtile_setup: q_valid=%b busy=%b, want 1 1", q_valid, busy);
    end
    reset = 1'b1;
    cycle();
    n_checks++;
    if (q_valid !== 1'b0 || q_output !== 0 || q_row !== '0 || q_col !== '0 || busy !== 1'b0 || done !== 1'b0 || buf_consume !== '0) begin
      n_fail++;
      $display("FAIL midtile_reset: q_valid=%b q_output=%0d row=%0d col=%0d busy=%b done=%b consume=%b, want all 0",
               q_valid, q_output, q_row, q_col, busy, done, buf_consume);
    end
    reset = 1'b0;
    clear_log();
    for (int k = 0; k < 6; k++) cycle();
    n_checks++;
    if (done_cnt != 0 || cons_any != 0 || qv_cnt != 0) begin
      n_fail++;
      $display("FAIL midtile_abandon: done=%0d consumes=%0d q_valid cycles=%0d, want 0 0 0", done_cnt, cons_any, qv_cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < NB; i++) push_ent(i, 32'(10 * (i + 1)), NBITS'(i), NBITS'(i));
    drive_bufs();
    pulse_start(4);
    run_to_done(50, "basic");
    for (int k = 0; k < 3; k++) cycle();
    n_checks++;
    if (obs.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d outputs, want 4", obs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs[k].val !== 32'(10 * (k + 1)) || obs[k].row !== NBITS'(k) || obs[k].col !== NBITS'(k) || obs_cyc[k] != obs_cyc[0] + k) begin
          n_fail++;
          $display("FAIL basic_out%0d: val=%0d row=%0d col=%0d cyc=%0d, want %0d %0d %0d %0d",
                   k, obs[k].val, obs[k].row, obs[k].col, obs_cyc[k], 10 * (k + 1), k, k, obs_cyc[0] + k);
        end
      end
      n_checks++;
      if (done_cyc != obs_cyc[3] + 1 || done_cnt != 1) begin
        n_fail++;
        $display("FAIL basic_done: done at %0d count %0d, want at %0d count 1", done_cyc, done_cnt, obs_cyc[3] + 1);
      end
    end
    for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (cons_cnt[i] != 1) begin
        n_fail++;
        $display("FAIL basic_consume%0d: got %0d, want 1", i, cons_cnt[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int seen = 0, hold = 0, v = -1, n = 0;
    do_reset();
    for (int i = 0; i < NB; i++) push_ent(i, 32'(10 * (i + 1)), NBITS'(i), NBITS'(i));
    drive_bufs();
    pulse_start(4);
    while (done_cnt == 0 && n < 60) begin
      if (q_valid && seen == 0) begin seen = 1; hold = 3; v = cyc; end
      q_ready = (hold == 0);
      #1;
      if (hold > 0) begin
        n_checks++;
        if (q_output !== 10 || buf_consume !== '0) begin
          n_fail++;
          $display("FAIL bp_hold: q_output=%0d consume=%b, want 10 0000", q_output, buf_consume);
        end
        hold--;
      end
      cycle();
      n++;
    end
    n_checks++;
    if (done_cnt != 1 || obs.size() != 4) begin
      n_fail++;
      $display("FAIL bp_complete: done=%0d outputs=%0d, want 1 4", done_cnt, obs.size());
    end else begin
      n_checks++;
      if (obs_cyc[0] != v + 3 || cons_cyc[1] != v + 3 || obs[1].val !== 32'd20 || obs_cyc[1] != v + 4) begin
        n_fail++;
        $display("FAIL bp_resume: 10 at %0d, consume1 at %0d, second=%0d at %0d, want %0d %0d 20 %0d",
                 obs_cyc[0], cons_cyc[1], obs[1].val, obs_cyc[1], v + 3, v + 3, v + 4);
      end
    end
    q_ready = 1'b1;
  endtask

  task automatic test_alternate();
    int want[6] = '{100, 200, 101, 201, 102, 202};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_ent(0, 32'(100 + k), 9'd0, NBITS'(k));
      push_ent(2, 32'(200 + k), 9'd2, NBITS'(k));
    end
    drive_bufs();
    pulse_start(6);
    run_to_done(80, "alt");
    n_checks++;
    if (obs.size() != 6) begin
      n_fail++;
      $display("FAIL alt_count: got %0d outputs, want 6", obs.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (obs[k].val !== 32'(want[k])) begin
          n_fail++;
          $display("FAIL alt_order%0d: got %0d, want %0d", k, obs[k].val, want[k]);
        end
      end
    end
    n_checks++;
    if (cons_cnt[1] != 0 || cons_cnt[3] != 0 || cons_cnt[0] != 3 || cons_cnt[2] != 3) begin
      n_fail++;
      $display("FAIL alt_consumes: got %0d %0d %0d %0d, want 3 0 3 0", cons_cnt[0], cons_cnt[1], cons_cnt[2], cons_cnt[3]);
    end
  endtask

  task automatic test_zero_tile();
    int s;
    do_reset();
    for (int i = 0; i < NB; i++) push_ent(i, 32'(i + 1), NBITS'(i), NBITS'(i));
    drive_bufs();
    s = cyc;
    pulse_start(0);
    run_to_done(20, "zero");
    cycle();
    n_checks++;
    if (done_cyc != s + 3 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_done: done at %0d count %0d, want at %0d count 1", done_cyc, done_cnt, s + 3);
    end
    n_checks++;
    if (cons_any != 0 || qv_cnt != 0) begin
      n_fail++;
      $display("FAIL zero_quiet: consumes=%0d q_valid cycles=%0d, want 0 0", cons_any, qv_cnt);
    end
  endtask

  task automatic test_flush_start();
    int n = 0;
    do_reset();
    for (int k = 0; k < 3; k++) push_ent(0, 32'(300 + k), 9'd0, NBITS'(k));
    for (int k = 0; k < 2; k++) push_ent(1, 32'(400 + k), 9'd1, NBITS'(k));
    drive_bufs();
    pulse_start(2);
    while ((cons_cnt[0] + cons_cnt[1]) < 2 && n < 20) begin cycle(); n++; end
    q_ready = 1'b0;
    cycle();
    tile_count = CB'(3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy: busy=%b, want 1", busy);
    end
    cycle();
    n_checks++;
    if (busy !== 1'b1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL flush_hold: busy=%b done=%0d, want 1 0", busy, done_cnt);
    end
    q_ready = 1'b1;
    run_to_done(20, "flush");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b after done, want 0", busy);
    end
    for (int k = 0; k < 5; k++) cycle();
    n_checks++;
    if (done_cnt != 1 || cons_cnt[0] + cons_cnt[1] != 2 || obs.size() != 2 || bq[0].size() != 2 || bq[1].size() != 1) begin
      n_fail++;
      $display("FAIL flush_totals: done=%0d consumes=%0d outputs=%0d left=%0d/%0d, want 1 2 2 2/1",
               done_cnt, cons_cnt[0] + cons_cnt[1], obs.size(), bq[0].size(), bq[1].size());
    end else begin
      n_checks++;
      if (obs[0].val !== 32'd300 || obs[1].val !== 32'd400) begin
        n_fail++;
        $display("FAIL flush_order: got %0d %0d, want 300 400", obs[0].val, obs[1].val);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int total = 0, tile, p, n = 0;
      do_reset();
      for (int i = 0; i < NB; i++) begin
        int cnt = $urandom_range(0, 5);
        for (int k = 0; k < cnt; k++) push_ent(i, $urandom, NBITS'($urandom_range(0, 511)), NBITS'($urandom_range(0, 511)));
        total += cnt;
      end
      if (total == 0) begin push_ent(1, 32'd77, 9'd3, 9'd4); total = 1; end
      tile = $urandom_range(1, total);
      for (int i = 0; i < NB; i++) mq[i] = bq[i];
      expq.delete();
      p = 0;
      for (int t = 0; t < tile; t++) begin
        int q;
        if (mq[p].size() == 0) p = next_ne(p);
        expq.push_back(mq[p].pop_front());
        q = next_ne(p);
        if (q >= 0) p = q;
      end
      drive_bufs();
      pulse_start(tile);
      while (done_cnt == 0 && n < 2000) begin
        q_ready = 1'($urandom_range(0, 1));
        cycle();
        n++;
      end
      q_ready = 1'b1;
      cycle();
      n_checks++;
      if (done_cnt != 1 || obs.size() != tile) begin
        n_fail++;
        $display("FAIL rand%0d_count: done=%0d outputs=%0d, want 1 %0d", it, done_cnt, obs.size(), tile);
      end else begin
        for (int k = 0; k < tile; k++) begin
          n_checks++;
          if (obs[k] !== expq[k]) begin
            n_fail++;
            $display("FAIL rand%0d_out%0d: got %h, want %h", it, k, obs[k], expq[k]);
          end
        end
        n_checks++;
        if (done_cyc != obs_cyc[tile - 1] + 1) begin
          n_fail++;
          $display("FAIL rand%0d_done: done at %0d, want %0d", it, done_cyc, obs_cyc[tile - 1] + 1);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin buf_output[i] = 0; buf_row[i] = '0; buf_col[i] = '0; end
    cyc = 0;
    clear_log();
    test_reset();
    test_basic();
    test_backpressure();
    test_alternate();
    test_zero_tile();
    test_flush_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
